// File: rtl/RAM_shared_pkg.sv
// -----------------------------------------------------------------------------
// RAM_shared_pkg
// Parameters shared by the RAM and every block that talks to it.
//   ADDR_SIZE : width of a RAM address and of a RAM data word
//   MEM_DEPTH : number of RAM locations
// -----------------------------------------------------------------------------
package RAM_shared_pkg;

  localparam int ADDR_SIZE = 8;
  localparam int MEM_DEPTH = 256;

endpackage : RAM_shared_pkg

// File: rtl/SPI_shared_pkg.sv
// -----------------------------------------------------------------------------
// SPI_shared_pkg
// Types and constants for the SPI front end of the SPI/RAM wrapper.
//   spi_state_e : slave FSM states
//   WORD_W      : serial command word width, {cmd[1:0], payload}
//   CMD_*       : command codes carried in word bits [WORD_W-1:WORD_W-2]
// -----------------------------------------------------------------------------
package SPI_shared_pkg;

  import RAM_shared_pkg::*;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam int WORD_W = ADDR_SIZE + 2;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage : SPI_shared_pkg

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// Master-facing end of the RAM command interface. Deserialises MOSI frames
// into {cmd[1:0], payload} words, strobes each one to the RAM with rx_valid,
// and for read-data commands serialises the RAM reply MSB-first on MISO.
//
// Ports
//   clk       in   system clock, also the SPI bit clock (MOSI sampled on posedge)
//   rst_n     in   asynchronous active-low reset
//   SS_n      in   slave select, active low; a frame is one low interval
//   MOSI      in   serial command data, MSB first
//   MISO      out  registered serial read data, MSB first
//   rx_data   out  assembled command word, [WORD_W-1:WORD_W-2] cmd, rest payload
//   rx_valid  out  one-cycle strobe qualifying rx_data
//   tx_data   in   read data from the RAM
//   tx_valid  in   strobe qualifying tx_data
// -----------------------------------------------------------------------------
module spi_slave
  import RAM_shared_pkg::*;
  import SPI_shared_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [WORD_W-1:0]    rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int TXC_W = $clog2(ADDR_SIZE);

  // rx_cnt counts received word bits; CNT_DONE means the word is complete and
  // any further MOSI bits in this frame are ignored.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WORD_W);
  localparam logic [TXC_W-1:0] TX_REST  = TXC_W'(ADDR_SIZE - 1);

  spi_state_e          state;
  logic [CNT_W-1:0]    rx_cnt;
  logic [WORD_W-1:0]   rx_shift;
  logic                rd_addr_received;
  logic [ADDR_SIZE-1:0] tx_shift;
  logic [TXC_W-1:0]    tx_left;
  logic                tx_taken;
  logic [WORD_W-1:0]   word_next;

  // Word as it will look once the current MOSI bit is shifted in; used on the
  // final bit so the strobed word and the flag update see the same value.
  assign word_next = {rx_shift[WORD_W-2:0], MOSI};

  // tx_left counts the reply bits still to be driven after bit 7, which goes
  // out on the same edge that latches tx_data. tx_taken limits the reply to
  // one per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      MISO             <= 1'b0;
      rx_data          <= '0;
      rx_valid         <= 1'b0;
      rx_cnt           <= '0;
      rx_shift         <= '0;
      rd_addr_received <= 1'b0;
      tx_shift         <= '0;
      tx_left          <= '0;
      tx_taken         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE && SS_n) begin
        // Frame end: partial words and unsent reply bits are dropped.
        state    <= IDLE;
        rx_cnt   <= '0;
        MISO     <= 1'b0;
        tx_shift <= '0;
        tx_left  <= '0;
        tx_taken <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n) begin
              state <= CHK_CMD;
            end
          end

          CHK_CMD: begin
            rx_shift <= {{(WORD_W-1){1'b0}}, MOSI};
            rx_cnt   <= CNT_W'(1);
            tx_taken <= 1'b0;
            if (!MOSI) begin
              state <= WRITE;
            end else if (!rd_addr_received) begin
              state <= READ_ADD;
            end else begin
              state <= READ_DATA;
            end
          end

          default: begin
            if (rx_cnt < CNT_DONE) begin
              rx_shift <= word_next;
              rx_cnt   <= rx_cnt + 1'b1;
              if (rx_cnt == CNT_LAST) begin
                rx_data  <= word_next;
                rx_valid <= 1'b1;
                if (word_next[WORD_W-1:WORD_W-2] == CMD_RD_ADDR) begin
                  rd_addr_received <= 1'b1;
                end else if (word_next[WORD_W-1:WORD_W-2] == CMD_RD_DATA) begin
                  rd_addr_received <= 1'b0;
                end
              end
            end else if (state == READ_DATA) begin
              if (tx_left != '0) begin
                MISO     <= tx_shift[ADDR_SIZE-1];
                tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
                tx_left  <= tx_left - 1'b1;
              end else if (tx_valid && !tx_taken) begin
                MISO     <= tx_data[ADDR_SIZE-1];
                tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                tx_left  <= TX_REST;
                tx_taken <= 1'b1;
              end else begin
                MISO <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Drives SPI frames into spi_slave, models the RAM side, and checks the
// strobed command words and the MISO reply stream against queued expectations.
// -----------------------------------------------------------------------------
module tb_spi_slave;
  import RAM_shared_pkg::*;
  import SPI_shared_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [WORD_W-1:0]    rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  int total = 0;
  int bad   = 0;

  logic [9:0] rxQ[$];
  logic [7:0] misoQ[$];
  int         strobeCount = 0;
  logic       prevValid = 1'b0;
  logic       ramMute;

  logic [7:0] mem [256];
  logic [7:0] wrAddr;
  logic [7:0] rdAddr;

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle reply to read-data commands.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (rx_data[9:8])
          2'b00: wrAddr <= rx_data[7:0];
          2'b01: mem[wrAddr] <= rx_data[7:0];
          2'b10: rdAddr <= rx_data[7:0];
          default: begin
            if (!ramMute) begin
              tx_data  <= mem[rdAddr];
              tx_valid <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Strobe monitor: pops the command-word scoreboard on each rx_valid.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid === 1'b1) begin
      strobeCount++;
      checkOutput("rx_valid_single", {31'b0, prevValid}, 32'd0);
      checkOutput("rx_expected", {31'b0, (rxQ.size() != 0)}, 32'd1);
      if (rxQ.size() != 0) begin
        checkOutput("rx_data", {22'b0, rx_data}, {22'b0, rxQ.pop_front()});
      end
    end
    prevValid = rx_valid;
  end

  // Drives one frame starting at a negedge; log[j] holds MISO sampled after
  // the j-th posedge of the frame (posedge 0 moves IDLE to CHK_CMD).
  task automatic applyStimulus(input logic [9:0] word, input int nbits,
                               input int tail, input int rstAt,
                               output logic [31:0] log);
    log  = '0;
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int j = 0; j <= nbits + tail; j++) begin
      @(negedge clk);
      log[j] = MISO;
      if (j == rstAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_miso", {31'b0, MISO}, 32'd0);
        checkOutput("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        checkOutput("rst_rx_data", {22'b0, rx_data}, 32'd0);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (j < nbits) begin
        MOSI = word[9-j];
      end else if (j < nbits + tail) begin
        MOSI = 1'($urandom_range(0, 1));
      end else begin
        SS_n = 1'b1;
        MOSI = 1'b0;
      end
    end
    @(negedge clk);
    log[nbits+tail+1] = MISO;
  endtask

  task automatic runFrame(input string name, input logic [9:0] word,
                          input int nbits, input int tail,
                          input bit expReply, input logic [7:0] replyByte);
    logic [31:0] log;
    logic [31:0] expLog;
    logic [7:0]  b;
    bit          expStrobe;
    expStrobe = (nbits == 10);
    if (expStrobe) rxQ.push_back(word);
    if (expReply) misoQ.push_back(replyByte);
    strobeCount = 0;
    $display("[TB] frame %s word=%03h bits=%0d", name, word, nbits);
    applyStimulus(word, nbits, tail, -1, log);
    checkOutput({name, "_strobes"}, strobeCount, expStrobe ? 32'd1 : 32'd0);
    checkOutput({name, "_rx_pending"}, rxQ.size(), 32'd0);
    expLog = '0;
    if (misoQ.size() != 0) begin
      b = misoQ.pop_front();
      for (int i = 0; i < 8; i++) expLog[12+i] = b[7-i];
    end
    checkOutput({name, "_miso"}, log, expLog);
  endtask

  initial begin
    logic [31:0] rlog;
    rst_n   = 1'b0;
    SS_n    = 1'b1;
    MOSI    = 1'b0;
    ramMute = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_miso", {31'b0, MISO}, 32'd0);
    checkOutput("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
    checkOutput("reset_rx_data", {22'b0, rx_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    runFrame("wr_addr", 10'h03C, 10, 2, 1'b0, 8'h00);
    runFrame("wr_data", 10'h1A5, 10, 2, 1'b0, 8'h00);
    runFrame("rd_addr", 10'h23C, 10, 12, 1'b0, 8'h00);
    runFrame("rd_data", 10'h300, 10, 12, 1'b1, 8'hA5);

    runFrame("abort", 10'h0FF, 7, 0, 1'b0, 8'h00);
    runFrame("after_abort", 10'h011, 10, 2, 1'b0, 8'h00);

    runFrame("wr_addr2", 10'h040, 10, 2, 1'b0, 8'h00);
    runFrame("wr_data2", 10'h15A, 10, 2, 1'b0, 8'h00);
    runFrame("rd_addr2", 10'h240, 10, 2, 1'b0, 8'h00);

    // Reset lands while MISO shows bit 3 of 0x5A.
    $display("[TB] frame rd_data_reset");
    rxQ.push_back(10'h300);
    applyStimulus(10'h300, 10, 12, 16, rlog);
    checkOutput("rst_rx_pending", rxQ.size(), 32'd0);
    checkOutput("rst_miso_prefix", {27'b0, rlog[12], rlog[13], rlog[14], rlog[15], rlog[16]},
                32'b01011);

    // Flag was cleared by reset: this read command goes to READ_ADD and the
    // RAM's reply must not reach MISO.
    runFrame("post_reset_rd", 10'h300, 10, 12, 1'b0, 8'h00);

    runFrame("rd_addr3", 10'h23C, 10, 2, 1'b0, 8'h00);
    ramMute = 1'b1;
    runFrame("no_reply", 10'h300, 10, 12, 1'b0, 8'h00);
    ramMute = 1'b0;

    runFrame("rd_addr4", 10'h23C, 10, 2, 1'b0, 8'h00);
    runFrame("rd_data4", 10'h300, 10, 12, 1'b1, 8'hA5);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_spi_slave
